// File: rtl/csa_stream_accumulator.sv
// Streaming packet accumulator that keeps its running total in carry-save form and resolves it once per packet.
// Optional macro CSA_STREAM_SAT_EN clamps out_sum to all-ones whenever the packet overflows.
module csa_stream_accumulator #(
   parameter int N = 8,
   parameter int K = 3,
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [K*N-1:0] in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_sum,
   output logic           out_overflow,
   output logic [15:0]    out_beats
);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

   // Row count after a given number of 3:2 reduction levels, starting from S, C and K operands.
   function automatic int rows_after(input int lvl);
      int r;
      r = K + 2;
      for (int i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
      return r;
   endfunction

   function automatic int tree_levels();
      int r;
      int n;
      r = K + 2;
      n = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + r % 3;
         n++;
      end
      return n;
   endfunction

   localparam int LEVELS = tree_levels();
   localparam int ROWS   = K + 2;

   state_t state_reg, state_next;

   logic [W-1:0]  s_reg, c_reg;
   logic          drop_reg;
   logic [15:0]   beats_reg;
   logic          valid_reg;
   logic [W-1:0]  sum_reg;
   logic          overflow_reg;
   logic [15:0]   out_beats_reg;

   logic          accept;
   logic          handshake;

   logic [W-1:0]  tree [0:LEVELS][0:ROWS-1];
   logic [LEVELS*ROWS-1:0] drop_bits;
   logic          tree_drop;

   logic [W:0]    add_full;
   logic          resolved_overflow;
   logic [W-1:0]  resolved_sum;

   genvar gi, li;

   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_leaf
         if (gi == 0) begin : g_s
            assign tree[0][gi] = s_reg;
         end else if (gi == 1) begin : g_c
            assign tree[0][gi] = c_reg;
         end else begin : g_op
            assign tree[0][gi] = W'(in_data[(gi-2)*N +: N]);
         end
      end

      // Each level groups rows in threes; leftover rows pass straight through.
      for (li = 0; li < LEVELS; li++) begin : g_level
         localparam int R = rows_after(li);
         localparam int G = R / 3;
         for (gi = 0; gi < ROWS; gi++) begin : g_row
            if (gi < 2 * G) begin : g_csa
               localparam int B = 3 * (gi / 2);
               if (gi % 2 == 0) begin : g_sum
                  assign tree[li+1][gi] = tree[li][B] ^ tree[li][B+1] ^ tree[li][B+2];
                  assign drop_bits[li*ROWS+gi] = 1'b0;
               end else begin : g_carry
                  logic [W-1:0] maj;
                  assign maj = (tree[li][B] & tree[li][B+1]) |
                               (tree[li][B] & tree[li][B+2]) |
                               (tree[li][B+1] & tree[li][B+2]);
                  assign tree[li+1][gi] = {maj[W-2:0], 1'b0};
                  assign drop_bits[li*ROWS+gi] = maj[W-1];
               end
            end else if (gi < 2 * G + R % 3) begin : g_pass
               assign tree[li+1][gi] = tree[li][3*G + gi - 2*G];
               assign drop_bits[li*ROWS+gi] = 1'b0;
            end else begin : g_unused
               assign tree[li+1][gi] = '0;
               assign drop_bits[li*ROWS+gi] = 1'b0;
            end
         end
      end
   endgenerate

   assign tree_drop = |drop_bits;

   // Any carry lost from the tree means the true total already reached 2^W.
   assign add_full          = {1'b0, s_reg} + {1'b0, c_reg};
   assign resolved_overflow = drop_reg | add_full[W];
`ifdef CSA_STREAM_SAT_EN
   assign resolved_sum = resolved_overflow ? {W{1'b1}} : add_full[W-1:0];
`else
   assign resolved_sum = add_full[W-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, ACCUM: begin
            if (accept) state_next = in_last ? RESOLVE : ACCUM;
         end
         RESOLVE: state_next = OUTPUT;
         OUTPUT: begin
            if (handshake) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && ((state_reg == IDLE) || (state_reg == ACCUM));
      accept    = in_valid && in_ready;
      handshake = (state_reg == OUTPUT) && valid_reg && out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg         <= '0;
         c_reg         <= '0;
         drop_reg      <= 1'b0;
         beats_reg     <= '0;
         valid_reg     <= 1'b0;
         sum_reg       <= '0;
         overflow_reg  <= 1'b0;
         out_beats_reg <= '0;
      end else begin
         if (accept) begin
            s_reg    <= tree[LEVELS][0];
            c_reg    <= tree[LEVELS][1];
            drop_reg <= drop_reg | tree_drop;
            if (beats_reg != 16'hFFFF) beats_reg <= beats_reg + 16'd1;
         end
         if (state_reg == RESOLVE) begin
            sum_reg       <= resolved_sum;
            overflow_reg  <= resolved_overflow;
            out_beats_reg <= beats_reg;
         end
         // Result is presented one cycle after it is registered.
         if (state_reg == OUTPUT && !valid_reg) valid_reg <= 1'b1;
         if (handshake) begin
            valid_reg <= 1'b0;
            s_reg     <= '0;
            c_reg     <= '0;
            drop_reg  <= 1'b0;
            beats_reg <= '0;
         end
      end
   end

   assign out_valid    = valid_reg;
   assign out_sum      = sum_reg;
   assign out_overflow = overflow_reg;
   assign out_beats    = out_beats_reg;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench: directed packets with literal results plus randomized traffic against a packet-level model.
module tb_csa_stream_accumulator;
   localparam int N = 8;
   localparam int K = 3;
   localparam int W = 12;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [K*N-1:0] in_data = '0;
   logic           in_last = 1'b0;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_sum;
   logic           out_overflow;
   logic [15:0]    out_beats;

   int checks = 0;
   int failures = 0;
   int ready_mode = 1;

   csa_stream_accumulator #(.N(N), .K(K), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow),
      .out_beats(out_beats)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packet-level model: running integer total, delivery two edges after the last beat.
   bit     m_busy = 0;
   int     m_age = 0;
   longint m_acc = 0;
   int     m_beats = 0;
   longint m_sum = 0;
   bit     m_ovf = 0;
   int     m_bts = 0;
   int     m_deliv = 0;
   int     dut_deliv = 0;

   always @(posedge clk or negedge rst_n) begin : model
      longint total;
      int nb;
      if (!rst_n) begin
         m_busy  <= 0;
         m_age   <= 0;
         m_acc   <= 0;
         m_beats <= 0;
      end else if (m_busy) begin
         if (m_age >= 2 && out_ready) begin
            m_busy  <= 0;
            m_acc   <= 0;
            m_beats <= 0;
            m_deliv <= m_deliv + 1;
         end else if (m_age < 3) begin
            m_age <= m_age + 1;
         end
      end else if (in_valid) begin
         total = m_acc;
         for (int j = 0; j < K; j++) total += 64'(in_data[j*N +: N]);
         nb = (m_beats < 65535) ? m_beats + 1 : 65535;
         m_acc   <= total;
         m_beats <= nb;
         if (in_last) begin
            m_busy <= 1;
            m_age  <= 0;
            m_ovf  <= (total >= (longint'(1) << W));
            m_bts  <= nb;
`ifdef CSA_STREAM_SAT_EN
            m_sum  <= (total >= (longint'(1) << W)) ? (longint'(1) << W) - 1 : total;
`else
            m_sum  <= total % (longint'(1) << W);
`endif
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) dut_deliv <= dut_deliv + 1;
   end

   always @(negedge clk) begin
      check("in_ready", 64'(in_ready), 64'(rst_n && !m_busy));
      check("out_valid", 64'(out_valid), 64'(rst_n && m_busy && m_age >= 2));
      if (!rst_n) begin
         check("rst_out_sum", 64'(out_sum), 64'(0));
         check("rst_out_overflow", 64'(out_overflow), 64'(0));
         check("rst_out_beats", 64'(out_beats), 64'(0));
      end else if (m_busy && m_age >= 2) begin
         check("out_sum", 64'(out_sum), 64'(m_sum));
         check("out_overflow", 64'(out_overflow), 64'(m_ovf));
         check("out_beats", 64'(out_beats), 64'(m_bts));
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic send_beat(input logic [K*N-1:0] data, input bit last);
      bit rdy;
      int n;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      n = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 50);
      check("beat_accepted", 64'(rdy), 64'(1));
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int cycles);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_result(input string name, input logic [W-1:0] es, input bit eo, input int eb);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, 64'(out_valid), 64'(1));
      check({name, "_sum"}, 64'(out_sum), 64'(es));
      check({name, "_overflow"}, 64'(out_overflow), 64'(eo));
      check({name, "_beats"}, 64'(out_beats), 64'(eb));
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [W-1:0] ovf_sum;
      int len;
      bit heavy;
      logic [K*N-1:0] d;
`ifdef CSA_STREAM_SAT_EN
      ovf_sum = 12'hFFF;
`else
      ovf_sum = 12'hFD0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single beat, exact latency
      send_beat({8'd3, 8'd2, 8'd1}, 1'b1);
      @(negedge clk);
      check("lat_edge_t", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("lat_edge_t1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("lat_edge_t2", 64'(out_valid), 64'(1));
      check("single_sum", 64'(out_sum), 64'(12'h006));
      check("single_overflow", 64'(out_overflow), 64'(0));
      check("single_beats", 64'(out_beats), 64'(1));
      @(posedge clk);
      #1;

      // Gap inside a packet
      send_beat({8'h01, 8'h01, 8'hFF}, 1'b0);
      idle(3);
      send_beat({8'h33, 8'h55, 8'hAA}, 1'b1);
      wait_result("gap", 12'h233, 1'b0, 2);

      // Overflow: 16 beats of FF
      for (int i = 0; i < 16; i++) send_beat({8'hFF, 8'hFF, 8'hFF}, i == 15);
      wait_result("ovf", ovf_sum, 1'b1, 16);

      // Reset mid-packet discards it
      send_beat({8'd7, 8'd6, 8'd5}, 1'b0);
      send_beat({8'd10, 8'd9, 8'd8}, 1'b0);
      do_reset(2);
      send_beat({8'd1, 8'd1, 8'd1}, 1'b1);
      wait_result("rst", 12'h003, 1'b0, 1);

      // Backpressure in OUTPUT with a new beat waiting
      ready_mode = 0;
      send_beat({8'd30, 8'd20, 8'd10}, 1'b1);
      fork
         send_beat({8'd3, 8'd2, 8'd1}, 1'b1);
         begin
            int n;
            n = 0;
            while (!out_valid && n < 10) begin
               @(negedge clk);
               n++;
            end
            check("hold_valid", 64'(out_valid), 64'(1));
            repeat (5) begin
               @(negedge clk);
               check("hold_sum", 64'(out_sum), 64'(12'h03C));
               check("hold_beats", 64'(out_beats), 64'(1));
               check("hold_in_ready", 64'(in_ready), 64'(0));
               check("hold_out_valid", 64'(out_valid), 64'(1));
            end
            ready_mode = 1;
         end
      join
      wait_result("after_hold", 12'h006, 1'b0, 1);

      // Back-to-back packets
      send_beat({8'd1, 8'd1, 8'd1}, 1'b0);
      send_beat({8'd2, 8'd2, 8'd2}, 1'b1);
      send_beat({8'd0, 8'd0, 8'd5}, 1'b1);
      wait_result("b2b", 12'h005, 1'b0, 1);

      // Randomized traffic with random backpressure and occasional resets
      ready_mode = 2;
      for (int p = 0; p < 300; p++) begin
         len   = $urandom_range(1, 6);
         heavy = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < len; b++) begin
            if (heavy)
               d = {8'($urandom_range(200, 255)), 8'($urandom_range(200, 255)), 8'($urandom_range(200, 255))};
            else
               d = K*N'($urandom);
            send_beat(d, b == len - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (b < len - 1 && $urandom_range(0, 39) == 0) begin
               do_reset($urandom_range(1, 3));
               break;
            end
         end
      end
      ready_mode = 1;
      idle(10);
      check("deliveries", 64'(dut_deliv), 64'(m_deliv));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
